// File: rtl/aes_demux_pkg.sv
// rtl/aes_demux_pkg.sv - shared types and default sizes for the AES ingress demux
package aes_demux_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    PACK = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEF_BUS_W       = 32;
  localparam int DEF_BLOCK_BYTES = 16;
  localparam int DEF_NFLAGS      = 32;

endpackage

// File: rtl/mod_block_packer.sv
// rtl/mod_block_packer.sv - beat counter plus byte-placement register for one plaintext block
// blk_next is the register with the current bus word merged into the slot selected by cnt.
module mod_block_packer
  import aes_demux_pkg::*;
#(
  parameter int BUS_W       = DEF_BUS_W,
  parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
  localparam int WB         = BUS_W / 8,
  localparam int BEATS      = BLOCK_BYTES * 8 / BUS_W,
  localparam int CW         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        wr,
  input  logic [BUS_W-1:0]            wr_data,
  input  logic                        ld,
  input  logic [BLOCK_BYTES-1:0][7:0] ld_data,
  output logic [CW-1:0]               cnt,
  output logic                        last,
  output logic [BLOCK_BYTES-1:0][7:0] blk,
  output logic [BLOCK_BYTES-1:0][7:0] blk_next
);

  byte_t [BLOCK_BYTES-1:0] pbuf_q;
  byte_t [BLOCK_BYTES-1:0] merged;
  logic  [CW-1:0]          cnt_q;

  // Constant-indexed placement keeps every byte select static.
  always_comb begin
    merged = pbuf_q;
    for (int k = 0; k < BEATS; k++) begin
      if (cnt_q == CW'(k)) begin
        for (int i = 0; i < WB; i++) begin
          merged[k*WB+i] = wr_data[8*i +: 8];
        end
      end
    end
  end

  assign last     = (cnt_q == CW'(BEATS - 1));
  assign cnt      = cnt_q;
  assign blk      = pbuf_q;
  assign blk_next = merged;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      pbuf_q <= '0;
    end else if (clear) begin
      cnt_q  <= '0;
      pbuf_q <= '0;
    end else if (ld) begin
      pbuf_q <= ld_data;
    end else if (wr) begin
      pbuf_q <= merged;
      cnt_q  <= last ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/mod_demux_ingress.sv
// rtl/mod_demux_ingress.sv - bus ingress demux: control-flag register and plaintext block packing
// Optional DEMUX_DBUF_EN adds a pending block slot so packing continues while a block is held.
module mod_demux_ingress
  import aes_demux_pkg::*;
#(
  parameter int BUS_W       = DEF_BUS_W,
  parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
  parameter int NFLAGS      = DEF_NFLAGS,
  localparam int BEATS      = BLOCK_BYTES * 8 / BUS_W,
  localparam int CW         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_addr,
  input  logic [BUS_W-1:0]            in_data,
  input  logic                        abort,
  output logic [NFLAGS-1:0]           flags_out,
  output logic                        flags_wr,
  output logic                        blk_valid,
  input  logic                        blk_ready,
  output logic [BLOCK_BYTES-1:0][7:0] blk_data,
  output logic [CW-1:0]               beat_cnt
);

  state_t state_q, state_d;
  logic   slot_free;
  logic   acc_ctrl, acc_data, last_acc, hs;
  logic   pk_last;
  logic   pend_q;
  logic [BLOCK_BYTES-1:0][7:0] pk_full, pend_blk, pk_blk_unused;

  assign in_ready  = in_addr ? (~abort & slot_free) : 1'b1;
  assign acc_ctrl  = in_valid & ~in_addr;
  assign acc_data  = in_valid & in_addr & in_ready;
  assign last_acc  = acc_data & pk_last;
  assign blk_valid = (state_q == HOLD);
  assign hs        = blk_valid & blk_ready;

  mod_block_packer #(.BUS_W(BUS_W), .BLOCK_BYTES(BLOCK_BYTES)) u_pack (
    .clk      (clk),
    .rst      (rst),
    .clear    (abort),
    .wr       (acc_data),
    .wr_data  (in_data),
    .ld       (1'b0),
    .ld_data  ('0),
    .cnt      (beat_cnt),
    .last     (pk_last),
    .blk      (pk_blk_unused),
    .blk_next (pk_full)
  );

`ifdef DEMUX_DBUF_EN
  logic                        pend_ld;
  logic [CW-1:0]               pend_cnt_unused;
  logic                        pend_last_unused;
  logic [BLOCK_BYTES-1:0][7:0] pend_next_unused;

  // A block completed while one is held and not leaving parks in the pending slot.
  assign slot_free = ~((state_q == HOLD) & pend_q);
  assign pend_ld   = last_acc & (state_q == HOLD) & ~hs;

  mod_block_packer #(.BUS_W(BUS_W), .BLOCK_BYTES(BLOCK_BYTES)) u_pend (
    .clk      (clk),
    .rst      (rst),
    .clear    (1'b0),
    .wr       (1'b0),
    .wr_data  ('0),
    .ld       (pend_ld),
    .ld_data  (pk_full),
    .cnt      (pend_cnt_unused),
    .last     (pend_last_unused),
    .blk      (pend_blk),
    .blk_next (pend_next_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          pend_q <= 1'b0;
    else if (pend_ld) pend_q <= 1'b1;
    else if (hs)      pend_q <= 1'b0;
  end
`else
  assign slot_free = (state_q == PACK);
  assign pend_q    = 1'b0;
  assign pend_blk  = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= PACK;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PACK:    if (last_acc) state_d = HOLD;
      HOLD:    if (hs)       state_d = (pend_q | last_acc) ? HOLD : PACK;
      default: state_d = PACK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_data <= '0;
    end else if (last_acc && (state_q == PACK || hs)) begin
      blk_data <= pk_full;
    end else if (hs && pend_q) begin
      blk_data <= pend_blk;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_out <= '0;
      flags_wr  <= 1'b0;
    end else begin
      flags_wr <= acc_ctrl;
      if (acc_ctrl) flags_out <= in_data[NFLAGS-1:0];
    end
  end

endmodule
